// File: rtl/aes_encryption.sv
// -----------------------------------------------------------------------------
// aes_encryption : iterative AES-128 encryption core (FIPS-197).
//
// One 128-bit block is processed at a time. Each round steps through
// KEY_ADD, SUB_BYTES, SHIFT_ROWS and MIX_COLUMNS. Round keys come from the
// aes_key_gen key-expansion block, indexed by the forward round number.
//
// Build option:
//   AES_ENC_PARALLEL_SBOX_EN  defined   : four sbox word instances, SUB_BYTES
//                                         takes 1 cycle (42-cycle latency)
//                             undefined : one shared sbox word, SUB_BYTES
//                                         takes 4 cycles (72-cycle latency)
//
// Ports (aes_encryption):
//   aclk, aresetn  clock (rising edge), asynchronous active-low reset
//   next           start pulse, taken only in IDLE while key_ready is high
//   key, key_init  cipher key and key-expansion start pulse
//   key_ready      key expansion complete
//   input_block    plaintext, sampled in the INIT cycle
//   output_block   ciphertext, held until the next DONE
//   block_ready    high from DONE until the next accepted start
//   busy           high in every state except IDLE
// -----------------------------------------------------------------------------

// Forward AES S-box applied to each byte of a 32-bit word. The byte map is
// the GF(2^8) inverse (x^254) followed by the FIPS-197 affine transform.
module aes_sbox_word (
    input  logic [31:0] word_i,
    output logic [31:0] sbox_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, b;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        b    = gf_mul(x252, x2);        // x^254, with 0 mapping to 0
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Byte-wise substitution of the whole word.
    always_comb begin
        sbox_o = {sbox_byte(word_i[31:24]), sbox_byte(word_i[23:16]),
                  sbox_byte(word_i[15:8]),  sbox_byte(word_i[7:0])};
    end
endmodule

// AES-128 key expansion: one round key per cycle after init_i, all eleven kept
// in registers. round_key_o is registered and so lags round_i by one cycle.
// Only keylen_i=0 (128-bit key) is supported; any other value never reports ready.
module aes_key_gen (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [127:0] key_i,
    input  logic         keylen_i,
    input  logic         init_i,
    input  logic [3:0]   round_i,
    output logic [127:0] round_key_o,
    output logic         ready_o
);
    logic [127:0] rk_q [0:10];
    logic [127:0] prev_q, next_s, round_key_q;
    logic [3:0]   step_q;
    logic         run_q, ready_q;
    logic [31:0]  sub_s, t_s, w0_s, w1_s, w2_s, w3_s;

    function automatic logic [7:0] rcon(input logic [3:0] step);
        case (step)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(last word)) of the previous round key.
    aes_sbox_word u_sbox (.word_i({prev_q[23:0], prev_q[31:24]}), .sbox_o(sub_s));

    // Next round key from the previous one.
    always_comb begin
        t_s    = sub_s ^ {rcon(step_q), 24'h000000};
        w0_s   = prev_q[127:96] ^ t_s;
        w1_s   = prev_q[95:64]  ^ w0_s;
        w2_s   = prev_q[63:32]  ^ w1_s;
        w3_s   = prev_q[31:0]   ^ w2_s;
        next_s = {w0_s, w1_s, w2_s, w3_s};
    end

    // Expansion sequencer, round-key store and registered key lookup.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 11; i++) rk_q[i] <= 128'h0;
            prev_q      <= 128'h0;
            step_q      <= 4'd0;
            run_q       <= 1'b0;
            ready_q     <= 1'b0;
            round_key_q <= 128'h0;
        end else begin
            if (init_i) begin
                rk_q[0] <= key_i;
                prev_q  <= key_i;
                step_q  <= 4'd1;
                run_q   <= 1'b1;
                ready_q <= 1'b0;
            end else if (run_q) begin
                rk_q[step_q] <= next_s;
                prev_q       <= next_s;
                if (step_q == 4'd10) begin
                    run_q   <= 1'b0;
                    ready_q <= 1'b1;
                end else begin
                    step_q <= step_q + 4'd1;
                end
            end else begin
                step_q <= step_q;
            end
            round_key_q <= (round_i <= 4'd10) ? rk_q[round_i] : 128'h0;
        end
    end

    assign round_key_o = round_key_q;
    assign ready_o     = ready_q & ~keylen_i;
endmodule

module aes_encryption #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         next,
    input  logic [127:0] key,
    input  logic         key_init,
    output logic         key_ready,
    input  logic [127:0] input_block,
    output logic [127:0] output_block,
    output logic         block_ready,
    output logic         busy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_KEY_ADD = 3'd2;
    localparam logic [2:0] S_SUB     = 3'd3;
    localparam logic [2:0] S_SHIFT   = 3'd4;
    localparam logic [2:0] S_MIX     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    logic [2:0]   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] data_q, data_d, out_q, out_d;
    logic         ready_q, ready_d, busy_q;
    logic [127:0] round_key_s;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k = column*4 + row; row r moves left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    aes_key_gen u_key_gen (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .key_i       (key),
        .keylen_i    (1'b0),
        .init_i      (key_init),
        .round_i     (round_q),
        .round_key_o (round_key_s),
        .ready_o     (key_ready)
    );

`ifdef AES_ENC_PARALLEL_SBOX_EN
    logic [127:0] sub_all_s;
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox_word u_sbox (.word_i(data_q[32*g+31 -: 32]), .sbox_o(sub_all_s[32*g+31 -: 32]));
    end
`else
    logic [1:0]  sub_cnt_q, sub_cnt_d;
    logic [31:0] sbox_in_s, sbox_out_s;

    aes_sbox_word u_sbox (.word_i(sbox_in_s), .sbox_o(sbox_out_s));

    // Word selected for the shared sbox; word 0 is the top 32 bits.
    always_comb begin
        case (sub_cnt_q)
            2'd0:    sbox_in_s = data_q[127:96];
            2'd1:    sbox_in_s = data_q[95:64];
            2'd2:    sbox_in_s = data_q[63:32];
            default: sbox_in_s = data_q[31:0];
        endcase
    end
`endif

    // Round sequencer; key_init outside IDLE aborts the block in progress.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        data_d  = data_q;
        out_d   = out_q;
        ready_d = ready_q;
`ifndef AES_ENC_PARALLEL_SBOX_EN
        sub_cnt_d = sub_cnt_q;
`endif
        if (key_init && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            round_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    round_d = 4'd0;
                    if (next && key_ready && !key_init) begin
                        ready_d = 1'b0;
                        state_d = S_INIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_INIT: begin
                    data_d  = input_block;
                    state_d = S_KEY_ADD;
                end
                S_KEY_ADD: begin
                    data_d = data_q ^ round_key_s;
                    if (round_q == LAST_ROUND) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = S_SUB;
`ifndef AES_ENC_PARALLEL_SBOX_EN
                        sub_cnt_d = 2'd0;
`endif
                    end
                end
                S_SUB: begin
`ifdef AES_ENC_PARALLEL_SBOX_EN
                    data_d  = sub_all_s;
                    state_d = S_SHIFT;
`else
                    case (sub_cnt_q)
                        2'd0:    data_d[127:96] = sbox_out_s;
                        2'd1:    data_d[95:64]  = sbox_out_s;
                        2'd2:    data_d[63:32]  = sbox_out_s;
                        default: data_d[31:0]   = sbox_out_s;
                    endcase
                    if (sub_cnt_q == 2'd3) begin
                        state_d = S_SHIFT;
                    end else begin
                        sub_cnt_d = sub_cnt_q + 2'd1;
                    end
`endif
                end
                S_SHIFT: begin
                    data_d = shift_rows(data_q);
                    if (round_q == LAST_ROUND) state_d = S_KEY_ADD;
                    else                       state_d = S_MIX;
                end
                S_MIX: begin
                    data_d  = {mix_col(data_q[127:96]), mix_col(data_q[95:64]),
                               mix_col(data_q[63:32]),  mix_col(data_q[31:0])};
                    state_d = S_KEY_ADD;
                end
                S_DONE: begin
                    out_d   = data_q;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end
            endcase
        end
    end

    // State and output registers; busy is registered from the next state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            data_q  <= 128'h0;
            out_q   <= 128'h0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            data_q  <= data_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifndef AES_ENC_PARALLEL_SBOX_EN
    // SUB_BYTES word counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) sub_cnt_q <= 2'd0;
        else          sub_cnt_q <= sub_cnt_d;
    end
`endif

    assign output_block = out_q;
    assign block_ready  = ready_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_aes_encryption.sv
// -----------------------------------------------------------------------------
// tb_aes_encryption : self-checking bench for aes_encryption. Known FIPS-197
// vectors plus random keys/plaintexts checked against a byte-level AES model
// built on a lookup-table S-box.
// -----------------------------------------------------------------------------
module tb_aes_encryption;
`ifdef AES_ENC_PARALLEL_SBOX_EN
    localparam int LAT = 42;
`else
    localparam int LAT = 72;
`endif
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PTC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CTC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         aclk = 1'b0;
    logic         aresetn, next, key_init, key_ready, block_ready, busy;
    logic [127:0] key, input_block, output_block;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]   sbox_tab [0:255];
    logic [2047:0] sb_hex;

    always #5 aclk = ~aclk;

    aes_encryption #(.NUM_ROUNDS(10)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .next         (next),
        .key          (key),
        .key_init     (key_init),
        .key_ready    (key_ready),
        .input_block  (input_block),
        .output_block (output_block),
        .block_ready  (block_ready),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Reference AES-128 encryption on byte arrays (FIPS-197 pseudo-code).
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [7:0] w [0:175];
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [7:0] tmp [0:3];
        logic [7:0] rc, t0;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = p[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                t0 = tmp[0];
                tmp[0] = sbox_tab[tmp[1]] ^ rc;
                tmp[1] = sbox_tab[tmp[2]];
                tmp[2] = sbox_tab[tmp[3]];
                tmp[3] = sbox_tab[t0];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int q = 0; q < 4; q++) t[q] = s[4*c+q];
                    s[4*c+0] = xt(t[0]) ^ (xt(t[1]) ^ t[1]) ^ t[2] ^ t[3];
                    s[4*c+1] = t[0] ^ xt(t[1]) ^ (xt(t[2]) ^ t[2]) ^ t[3];
                    s[4*c+2] = t[0] ^ t[1] ^ xt(t[2]) ^ (xt(t[3]) ^ t[3]);
                    s[4*c+3] = (xt(t[0]) ^ t[0]) ^ t[1] ^ t[2] ^ xt(t[3]);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_key_ready(input string tag);
        int n;
        n = 0;
        while (!key_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check(tag, key_ready, 1'b1);
    endtask

    task automatic load_key(input logic [127:0] k);
        key = k;
        key_init = 1'b1;
        @(negedge aclk);
        key_init = 1'b0;
        wait_key_ready("key_ready");
    endtask

    // Called at a negedge. mode 0: plain, 1: extra next pulses while busy,
    // 2: key_init at cycle 20, 3: aresetn low at cycle 40.
    task automatic run_op(input int mode, input logic [127:0] pt, input logic [127:0] exp_ct,
                          input logic [127:0] prev_out, input logic [127:0] new_key,
                          input string tag);
        int cyc;
        bit done, busy_gap;
        next = 1'b1;
        input_block = pt;
        @(posedge aclk);
        cyc = 0;
        done = 1'b0;
        busy_gap = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge aclk);
            next = (mode == 1) && (cyc == 10 || cyc == 30);
            key_init = 1'b0;
            if (cyc == 0) check({tag, "_br_fall"}, block_ready, 1'b0);
            if (cyc >= 1) input_block = rand128();
            if (mode == 2 && cyc == 21) begin
                check({tag, "_abort_busy"}, busy, 1'b0);
                check({tag, "_abort_br"}, block_ready, 1'b0);
                check({tag, "_abort_out"}, output_block, prev_out);
                return;
            end
            if (mode == 3 && cyc == 40) begin
                aresetn = 1'b0;
                #1;
                check({tag, "_rst_out"}, output_block, 128'h0);
                check({tag, "_rst_br"}, block_ready, 1'b0);
                check({tag, "_rst_busy"}, busy, 1'b0);
                check({tag, "_rst_kready"}, key_ready, 1'b0);
                @(negedge aclk);
                aresetn = 1'b1;
                @(negedge aclk);
                return;
            end
            if (block_ready) begin
                done = 1'b1;
            end else begin
                if (!busy) busy_gap = 1'b1;
                if (mode == 2 && cyc == 20) begin
                    key = new_key;
                    key_init = 1'b1;
                end
                @(posedge aclk);
                cyc++;
            end
        end
        check({tag, "_latency"}, 128'(cyc), 128'(LAT));
        check({tag, "_ct"}, output_block, exp_ct);
        check({tag, "_busy_held"}, 128'(busy_gap), 128'h0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [127:0] k, pt, last_ct;
        sb_hex = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                  128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                  128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                  128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                  128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                  128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                  128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                  128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox_tab[i] = sb_hex[2047-8*i -: 8];

        aresetn = 1'b0;
        next = 1'b0;
        key_init = 1'b0;
        key = 128'h0;
        input_block = 128'h0;
        repeat (3) @(negedge aclk);
        check("reset_out", output_block, 128'h0);
        check("reset_br", block_ready, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_kready", key_ready, 1'b0);
        aresetn = 1'b1;
        @(negedge aclk);

        load_key(KB);
        run_op(0, PTB, CTB, 128'h0, 128'h0, "fips_b");
        load_key(KC);
        run_op(0, PTC, CTC, 128'h0, 128'h0, "fips_c1");
        run_op(0, 128'h0, aes_ref(KC, 128'h0), 128'h0, 128'h0, "back2back");
        last_ct = aes_ref(KC, 128'h0);

        for (int i = 0; i < 4; i++) begin
            k = rand128();
            pt = rand128();
            load_key(k);
            run_op((i == 1) ? 1 : 0, pt, aes_ref(k, pt), 128'h0, 128'h0, (i == 1) ? "next_busy" : "random");
            last_ct = aes_ref(k, pt);
        end

        // next while the key is still expanding is ignored
        k = rand128();
        key = k;
        key_init = 1'b1;
        @(negedge aclk);
        key_init = 1'b0;
        next = 1'b1;
        @(negedge aclk);
        next = 1'b0;
        check("nokey_busy", busy, 1'b0);
        check("nokey_br", block_ready, 1'b1);
        @(negedge aclk);
        check("nokey_busy2", busy, 1'b0);
        wait_key_ready("nokey_kready");

        // abort with a new key, then encrypt under that key
        pt = rand128();
        begin
            logic [127:0] k2;
            k2 = rand128();
            run_op(2, pt, 128'h0, last_ct, k2, "abort");
            wait_key_ready("abort_kready");
            pt = rand128();
            run_op(0, pt, aes_ref(k2, pt), 128'h0, 128'h0, "after_abort");
        end

        // reset mid-operation, then Appendix B again
        load_key(KB);
        run_op(3, PTB, 128'h0, 128'h0, 128'h0, "midreset");
        load_key(KB);
        run_op(0, PTB, CTB, 128'h0, 128'h0, "fips_b_again");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
